// File: rtl/execute_cycle_pkg.sv
// Shared pipeline constants and types: decode-stage encodings, ALU op codes,
// forwarding selects and the EX/MEM register layout.
package execute_cycle_pkg;

    // Decode-stage opcodes (RV32I subset handled by this pipeline)
    localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPCODE_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10
    } imm_src_t;

    // ALU operation codes; every other code yields zero
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Forwarding selects; 2'b11 falls back to the register-file value
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        result_src;
        logic [4:0]  rd;
        logic [31:0] pc_plus4;
        logic [31:0] write_data;
        logic [31:0] alu_result;
    } ex_mem_t;

    function automatic logic [31:0] fwd_mux(
        input logic [1:0]  sel,
        input logic [31:0] rf_val,
        input logic [31:0] wb_val,
        input logic [31:0] mem_val
    );
        case (sel)
            FWD_WB:  fwd_mux = wb_val;
            FWD_MEM: fwd_mux = mem_val;
            default: fwd_mux = rf_val;
        endcase
    endfunction

endpackage

// File: rtl/execute_cycle_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the execute stage.
interface execute_cycle_if;
    logic        RegWriteE;
    logic        ALUSrcE;
    logic        MemWriteE;
    logic        ResultSrcE;
    logic        BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E;
    logic [31:0] RD2_E;
    logic [31:0] Imm_Ext_E;
    logic [4:0]  RD_E;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [1:0]  ForwardA_E;
    logic [1:0]  ForwardB_E;
    logic [31:0] ResultW;

    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M;
    logic [31:0] WriteDataM;
    logic [31:0] ALUResultM;

    modport master (
        output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
               ForwardA_E, ForwardB_E, ResultW,
        input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               PCPlus4M, WriteDataM, ALUResultM
    );

    modport slave (
        input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
               ForwardA_E, ForwardB_E, ResultW,
        output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               PCPlus4M, WriteDataM, ALUResultM
    );
endinterface

// File: rtl/execute_cycle_alu.sv
// 32-bit ALU: add/sub (wrapping), and, or, signed set-less-than; zero flag.
module alu
    import execute_cycle_pkg::*;
(
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [2:0]  ALUControl,
    output logic [31:0] Result,
    output logic        Zero
);

    always_comb begin
        Result = 32'd0;
        case (ALUControl)
            ALU_ADD: Result = SrcA + SrcB;
            ALU_SUB: Result = SrcA - SrcB;
            ALU_AND: Result = SrcA & SrcB;
            ALU_OR:  Result = SrcA | SrcB;
            ALU_SLT: Result = {31'd0, $signed(SrcA) < $signed(SrcB)};
            default: Result = 32'd0;
        endcase
    end

    assign Zero = (Result == 32'd0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: forwarding muxes, ALU, branch resolution/target and the
// EX/MEM pipeline register.
module execute_cycle
    import execute_cycle_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    execute_cycle_if.slave    ex
);

    ex_mem_t     ex_mem_reg;
    ex_mem_t     ex_mem_next;
    logic [31:0] src_a;
    logic [31:0] fwd_b;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic        alu_zero;

    // MEM-stage forwarding reads the live EX/MEM register so dependent
    // back-to-back ALU ops need no bubble
    assign src_a = fwd_mux(ex.ForwardA_E, ex.RD1_E, ex.ResultW, ex_mem_reg.alu_result);
    assign fwd_b = fwd_mux(ex.ForwardB_E, ex.RD2_E, ex.ResultW, ex_mem_reg.alu_result);
    assign src_b = ex.ALUSrcE ? ex.Imm_Ext_E : fwd_b;

    alu u_alu (
        .SrcA       (src_a),
        .SrcB       (src_b),
        .ALUControl (ex.ALUControlE),
        .Result     (alu_result),
        .Zero       (alu_zero)
    );

    assign ex.PCSrcE    = ex.BranchE & alu_zero;
    assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;

    // Store data is always the forwarded rs2, never the immediate
    always_comb begin
        ex_mem_next            = '0;
        ex_mem_next.reg_write  = ex.RegWriteE;
        ex_mem_next.mem_write  = ex.MemWriteE;
        ex_mem_next.result_src = ex.ResultSrcE;
        ex_mem_next.rd         = ex.RD_E;
        ex_mem_next.pc_plus4   = ex.PCPlus4E;
        ex_mem_next.write_data = fwd_b;
        ex_mem_next.alu_result = alu_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_reg <= '0;
        end else begin
            ex_mem_reg <= ex_mem_next;
        end
    end

    assign ex.RegWriteM  = ex_mem_reg.reg_write;
    assign ex.MemWriteM  = ex_mem_reg.mem_write;
    assign ex.ResultSrcM = ex_mem_reg.result_src;
    assign ex.RD_M       = ex_mem_reg.rd;
    assign ex.PCPlus4M   = ex_mem_reg.pc_plus4;
    assign ex.WriteDataM = ex_mem_reg.write_data;
    assign ex.ALUResultM = ex_mem_reg.alu_result;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed-vector bench for execute_cycle with hand-computed expectations.
module tb_execute_cycle;
    import execute_cycle_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    execute_cycle_if ex ();

    execute_cycle dut (
        .clk (clk),
        .rst (rst),
        .ex  (ex.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vec %0d %s: observed %h expected %h", vectors, tag, obs, exp);
    endtask

    // Drive one instruction's datapath fields just after a falling edge
    task automatic drive(input logic [2:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic alusrc,
                         input logic [1:0] fa, input logic [1:0] fb);
        @(negedge clk);
        ex.ALUControlE = op;
        ex.RD1_E       = rd1;
        ex.RD2_E       = rd2;
        ex.Imm_Ext_E   = imm;
        ex.ALUSrcE     = alusrc;
        ex.ForwardA_E  = fa;
        ex.ForwardB_E  = fb;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_m_zero(input string tag);
        chk({tag, " RegWriteM"},  32'(ex.RegWriteM),  32'd0);
        chk({tag, " MemWriteM"},  32'(ex.MemWriteM),  32'd0);
        chk({tag, " ResultSrcM"}, 32'(ex.ResultSrcM), 32'd0);
        chk({tag, " RD_M"},       32'(ex.RD_M),       32'd0);
        chk({tag, " PCPlus4M"},   ex.PCPlus4M,        32'd0);
        chk({tag, " WriteDataM"}, ex.WriteDataM,      32'd0);
        chk({tag, " ALUResultM"}, ex.ALUResultM,      32'd0);
    endtask

    initial begin
        // In-flight garbage while reset is held
        ex.RegWriteE = 1'b1; ex.MemWriteE = 1'b1; ex.ResultSrcE = 1'b1; ex.BranchE = 1'b1;
        ex.RD_E = 5'd7; ex.PCE = 32'h10; ex.PCPlus4E = 32'h14; ex.ResultW = 32'd0;
        ex.ALUControlE = ALU_SUB; ex.RD1_E = 32'd1; ex.RD2_E = 32'd1; ex.Imm_Ext_E = 32'd4;
        ex.ALUSrcE = 1'b0; ex.ForwardA_E = FWD_RF; ex.ForwardB_E = FWD_RF;
        repeat (2) @(posedge clk);
        #1;
        chk_all_m_zero("reset");
        chk("reset PCTargetE live", ex.PCTargetE, 32'h14);
        chk("reset PCSrcE live", 32'(ex.PCSrcE), 32'd1);

        // Plain add 5+7
        @(negedge clk);
        rst = 1'b0;
        ex.RegWriteE = 1'b1; ex.MemWriteE = 1'b0; ex.ResultSrcE = 1'b0; ex.BranchE = 1'b0;
        ex.RD_E = 5'd3; ex.PCE = 32'h100; ex.PCPlus4E = 32'h104;
        drive(ALU_ADD, 32'd5, 32'd7, 32'd0, 1'b0, FWD_RF, FWD_RF);
        chk("add PCSrcE", 32'(ex.PCSrcE), 32'd0);
        chk("add PCTargetE", ex.PCTargetE, 32'h100);
        tick();
        chk("add ALUResultM", ex.ALUResultM, 32'd12);
        chk("add RegWriteM", 32'(ex.RegWriteM), 32'd1);
        chk("add RD_M", 32'(ex.RD_M), 32'd3);
        chk("add PCPlus4M", ex.PCPlus4M, 32'h104);
        chk("add WriteDataM", ex.WriteDataM, 32'd7);
        chk("add MemWriteM", 32'(ex.MemWriteM), 32'd0);

        // Back-to-back dependency through ALUResultM, stale RD1
        ex.RD_E = 5'd4; ex.PCPlus4E = 32'h108;
        drive(ALU_ADD, 32'd0, 32'd3, 32'd0, 1'b0, FWD_MEM, FWD_RF);
        tick();
        chk("fwdA mem ALUResultM", ex.ALUResultM, 32'd15);
        chk("fwdA mem RD_M", 32'(ex.RD_M), 32'd4);
        chk("fwdA mem PCPlus4M", ex.PCPlus4M, 32'h108);

        // Store with rs2 forwarded from writeback
        ex.RegWriteE = 1'b0; ex.MemWriteE = 1'b1; ex.ResultW = 32'd4;
        drive(ALU_ADD, 32'h20, 32'd99, 32'd8, 1'b1, FWD_RF, FWD_WB);
        tick();
        chk("store ALUResultM", ex.ALUResultM, 32'h28);
        chk("store WriteDataM", ex.WriteDataM, 32'd4);
        chk("store MemWriteM", 32'(ex.MemWriteM), 32'd1);
        chk("store RegWriteM", 32'(ex.RegWriteM), 32'd0);

        // Store with rs2 forwarded from MEM stage
        drive(ALU_ADD, 32'h40, 32'd0, 32'd0, 1'b1, FWD_RF, FWD_MEM);
        tick();
        chk("fwdB mem WriteDataM", ex.WriteDataM, 32'h28);
        chk("fwdB mem ALUResultM", ex.ALUResultM, 32'h40);

        // Immediate add wraps; store data is RD2, not the immediate
        ex.RegWriteE = 1'b1; ex.MemWriteE = 1'b0; ex.ResultSrcE = 1'b1;
        drive(ALU_ADD, 32'h7FFF_FFFF, 32'd5, 32'd1, 1'b1, FWD_RF, FWD_RF);
        tick();
        chk("wrap ALUResultM", ex.ALUResultM, 32'h8000_0000);
        chk("wrap WriteDataM", ex.WriteDataM, 32'd5);
        chk("wrap ResultSrcM", 32'(ex.ResultSrcM), 32'd1);

        ex.ResultSrcE = 1'b0;
        drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, FWD_RF, FWD_RF);
        tick();
        chk("slt -1<1", ex.ALUResultM, 32'd1);
        drive(ALU_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, FWD_RF, FWD_RF);
        tick();
        chk("slt 1<-1", ex.ALUResultM, 32'd0);
        drive(ALU_SUB, 32'd10, 32'd3, 32'd0, 1'b0, FWD_RF, FWD_RF);
        tick();
        chk("sub 10-3", ex.ALUResultM, 32'd7);
        drive(ALU_SUB, 32'd0, 32'd1, 32'd0, 1'b0, FWD_RF, FWD_RF);
        tick();
        chk("sub 0-1", ex.ALUResultM, 32'hFFFF_FFFF);
        drive(ALU_AND, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, FWD_RF, FWD_RF);
        tick();
        chk("and", ex.ALUResultM, 32'hF000);
        drive(ALU_OR, 32'hF0F0, 32'h0F0F, 32'd0, 1'b0, FWD_RF, FWD_RF);
        tick();
        chk("or", ex.ALUResultM, 32'hFFFF);
        drive(3'b111, 32'd5, 32'd7, 32'd0, 1'b0, FWD_RF, FWD_RF);
        tick();
        chk("op111 zero", ex.ALUResultM, 32'd0);
        drive(ALU_OR, 32'd1, 32'd2, 32'd0, 1'b0, FWD_RF, FWD_RF);
        tick();
        chk("or 1|2", ex.ALUResultM, 32'd3);
        drive(3'b100, 32'd5, 32'd7, 32'd0, 1'b0, FWD_RF, FWD_RF);
        tick();
        chk("op100 zero", ex.ALUResultM, 32'd0);

        // Select 11 acts as 00 on both operands
        ex.ResultW = 32'd100;
        drive(ALU_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 2'b11, 2'b11);
        tick();
        chk("fwd11 ALUResultM", ex.ALUResultM, 32'd12);
        chk("fwd11 WriteDataM", ex.WriteDataM, 32'd7);
        drive(ALU_ADD, 32'd5, 32'd7, 32'd0, 1'b0, FWD_WB, FWD_RF);
        tick();
        chk("fwdA wb ALUResultM", ex.ALUResultM, 32'd107);

        // BEQ resolution, combinational in the same cycle
        ex.RegWriteE = 1'b0; ex.BranchE = 1'b1; ex.PCE = 32'h100;
        drive(ALU_SUB, 32'd9, 32'd9, 32'hFFFF_FFF8, 1'b0, FWD_RF, FWD_RF);
        chk("beq taken PCSrcE", 32'(ex.PCSrcE), 32'd1);
        chk("beq PCTargetE", ex.PCTargetE, 32'hF8);
        drive(ALU_SUB, 32'd9, 32'd8, 32'hFFFF_FFF8, 1'b0, FWD_RF, FWD_RF);
        chk("beq not taken PCSrcE", 32'(ex.PCSrcE), 32'd0);
        ex.BranchE = 1'b0;
        drive(ALU_SUB, 32'd9, 32'd9, 32'hFFFF_FFF8, 1'b0, FWD_RF, FWD_RF);
        chk("no branch zero PCSrcE", 32'(ex.PCSrcE), 32'd0);

        // Reset mid-stream discards the in-flight store
        ex.MemWriteE = 1'b1; ex.RegWriteE = 1'b1; ex.ResultSrcE = 1'b1;
        ex.RD_E = 5'd9; ex.PCPlus4E = 32'h200;
        drive(ALU_ADD, 32'd1, 32'd2, 32'd0, 1'b0, FWD_RF, FWD_RF);
        tick();
        chk("pre-rst MemWriteM", 32'(ex.MemWriteM), 32'd1);
        drive(ALU_ADD, 32'd3, 32'd4, 32'd16, 1'b0, FWD_RF, FWD_RF);
        rst = 1'b1;
        tick();
        chk_all_m_zero("midrst");
        chk("midrst PCTargetE live", ex.PCTargetE, 32'h110);

        @(negedge clk);
        rst = 1'b0;
        ex.MemWriteE = 1'b0; ex.ResultSrcE = 1'b0;
        drive(ALU_ADD, 32'd5, 32'd7, 32'd0, 1'b0, FWD_RF, FWD_RF);
        tick();
        chk("post-rst ALUResultM", ex.ALUResultM, 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
